irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter N_IRQ, default 4: number of interrupt sources, range 1..8.
REQ-002 Parameter PC_W, default 9: program-counter and vector width.
REQ-003 Parameter BASE_ADDR, default 9'd256: vector of source 0.
REQ-004 Parameter STRIDE, default 4: vector spacing between sources.
REQ-005 Parameter EDGE, default 1: 1 = rising-edge sources, 0 = level sources.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 irq_in  in  N_IRQ  raw source lines, already synchronous to clk.
REQ-009 en_wr  in  1  load the enable register from en_data.
REQ-010 en_data  in  N_IRQ  new enable mask; 1 = source enabled.
REQ-011 ack  in  1  control FSM has saved PC and is taking the request.
REQ-012 eoi  in  1  return-from-interrupt strobe, one cycle.
REQ-013 irq_req  out  1  interrupt request to the control FSM (registered).
REQ-014 irq_vec  out  PC_W  PC load value for the requested source.
REQ-015 irq_id  out  3  index of the requested or last-acknowledged source.
REQ-016 in_service  out  1  OR of all in-service bits; replaces the single mask bit.

Function
REQ-017 Pending register: in EDGE=1 a bit is set on a 0->1 transition of irq_in, detected against a registered copy. In EDGE=0 pending equals irq_in.
REQ-018 Candidate = pending & enable. Priority is fixed; a lower index has higher priority.
REQ-019 A candidate is eligible only if its index is lower than the index of the highest-priority in-service bit, or if no bit is in service. This gives nested preemption.
REQ-020 States:
- IDLE -> REQ when an eligible candidate exists.
- REQ -> HOLD on ack.
- REQ -> IDLE if the eligible candidate vanishes before ack (withdrawal).
- HOLD -> IDLE unconditionally after one cycle.
REQ-021 irq_req = 1 exactly in REQ.
REQ-022 In REQ, irq_id tracks the highest-priority eligible candidate every cycle; a higher-priority arrival replaces it without leaving REQ.
REQ-023 irq_vec = BASE_ADDR + irq_id*STRIDE, truncated to PC_W bits. It is valid whenever irq_req=1 and is held through HOLD.
REQ-024 On ack in REQ, in the same edge:
- set isr[irq_id];
- in EDGE=1, clear pending[irq_id];
- freeze irq_id.
REQ-025 ack while not in REQ is ignored.
REQ-026 eoi clears the highest-priority set isr bit; eoi with isr=0 is ignored.
REQ-027 ack and eoi in the same cycle: eoi clears against the pre-ack isr, then ack sets its bit. The newly acked bit is never cleared by that eoi.
REQ-028 A new rising edge on a source in the same cycle that ack clears its pending bit leaves pending set; the edge wins.
REQ-029 en_wr takes effect next cycle. Disabling a source never clears its pending or isr bit.
REQ-030 Counts of IRQ sources above 8 are a parameter error; elaboration shall fail.

Reset
REQ-031 Reset forces:
- state = IDLE;
- pending, isr and enable = 0;
- the edge-detect copy = 0;
- irq_req = 0, irq_id = 0, irq_vec = BASE_ADDR, in_service = 0.
REQ-032 Reset mid-REQ or mid-service drops irq_req in the same cycle (asynchronous). No edge is latched from a line already high at reset release until it falls and rises again.

Structure
REQ-033 State encodings (IDLE, REQ, HOLD), the default BASE_ADDR and STRIDE shall live in a shared package, alongside the CPU state encodings.
REQ-034 One sub-module, irq_prio_enc: a combinational N_IRQ-input lowest-index-first encoder with a valid output. It is instantiated twice: once for candidates and once for isr.
REQ-035 All flops use the existing register style with asynchronous reset. No latches.

Verification
REQ-036 Rise irq_in[2] with enable=4'b0100 -> irq_req=1 two edges later, irq_id=2, irq_vec=264. On ack: irq_req=0, in_service=1.
REQ-037 Source 2 in service, rise irq_in[0] (enabled) -> irq_req=1, irq_id=0, vector 256. Rise irq_in[3] instead -> no request until eoi.
REQ-038 Pending 3 and 1 simultaneously -> id 1 first. After ack, eoi, and another request cycle, id 3 is served.
REQ-039 ack and eoi on the same edge with isr=4'b0100, ack id 0 -> isr=4'b0001.
REQ-040 In REQ, drop enable for the sole candidate -> IDLE next cycle, irq_req=0, pending still 1. Re-enable -> request again.
REQ-041 Assert reset while in REQ with irq_in held high -> irq_req=0 immediately. After release, no request until irq_in toggles.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// irq_ctrl_pkg
// Shared definitions for the interrupt controller and the CPU control FSM
// that consumes its request.
//   - irq_state_e : request handshake states of the interrupt controller
//   - cpu_state_e : control-FSM states of the CPU core
//   - DEFAULT_BASE_ADDR / DEFAULT_STRIDE : default vector table layout
//   - irq_vector() : vector address of a source, before truncation to PC width
// ---------------------------------------------------------------------------
package irq_ctrl_pkg;

    // Interrupt controller handshake states.
    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_HOLD = 2'd2
    } irq_state_e;

    // CPU control FSM states. The core enters CPU_IRQ_SAVE when it sees
    // irq_req, raises ack while saving the PC, then jumps to irq_vec.
    typedef enum logic [2:0] {
        CPU_FETCH    = 3'd0,
        CPU_DECODE   = 3'd1,
        CPU_EXECUTE  = 3'd2,
        CPU_MEMORY   = 3'd3,
        CPU_IRQ_SAVE = 3'd4,
        CPU_IRQ_JUMP = 3'd5,
        CPU_HALT     = 3'd6
    } cpu_state_e;

    localparam int unsigned DEFAULT_BASE_ADDR = 256;
    localparam int unsigned DEFAULT_STRIDE    = 4;
    localparam int unsigned MAX_IRQ           = 8;

    // Vector of a source in full 32-bit arithmetic; the caller truncates
    // to its program-counter width.
    function automatic int unsigned irq_vector(
        input int unsigned base,
        input int unsigned id,
        input int unsigned stride
    );
        return base + id * stride;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
// Combinational fixed-priority encoder: the lowest set index wins.
// Ports:
//   req   [N-1:0] in  : request vector
//   valid         out : at least one request bit set
//   id    [2:0]   out : index of the lowest set bit (0 when none set)
// ---------------------------------------------------------------------------
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [2:0]   id
);

    always_comb begin
        valid = |req;
        id    = '0;
        // Scan downward so the last match, i.e. the lowest index, sticks.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl
// Vectored, nested, fixed-priority interrupt controller.
// Ports:
//   clk         in             : clock, rising edge
//   reset       in             : asynchronous active-high reset
//   irq_in      in  [N_IRQ-1:0]: source lines, synchronous to clk
//   en_wr       in             : load enable mask from en_data
//   en_data     in  [N_IRQ-1:0]: new enable mask (1 = enabled)
//   ack         in             : CPU takes the current request
//   eoi         in             : end of interrupt, one-cycle strobe
//   irq_req     out            : registered request to the CPU
//   irq_vec     out [PC_W-1:0] : PC load value for irq_id
//   irq_id      out [2:0]      : requested / last acknowledged source
//   in_service  out            : any source currently in service
// ---------------------------------------------------------------------------
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int              N_IRQ     = 4,
    parameter int              PC_W      = 9,
    parameter logic [PC_W-1:0] BASE_ADDR = PC_W'(DEFAULT_BASE_ADDR),
    parameter int              STRIDE    = DEFAULT_STRIDE,
    parameter int              EDGE      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             en_wr,
    input  logic [N_IRQ-1:0] en_data,
    input  logic             ack,
    input  logic             eoi,
    output logic             irq_req,
    output logic [PC_W-1:0]  irq_vec,
    output logic [2:0]       irq_id,
    output logic             in_service
);

    // Refuse to elaborate with an unsupported source count; irq_id is 3 bits.
    generate
        if (N_IRQ < 1 || N_IRQ > MAX_IRQ) begin : g_bad_n_irq
            $error("irq_ctrl: N_IRQ must be in the range 1..8");
        end
    endgenerate

    irq_state_e       state_q, state_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] isr_q, isr_d;
    logic [N_IRQ-1:0] enable_q, enable_d;
    logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic             armed_q, armed_d;
    logic             irq_req_q, irq_req_d;
    logic [2:0]       irq_id_q, irq_id_d;
    logic [PC_W-1:0]  irq_vec_q, irq_vec_d;

    logic [N_IRQ-1:0] pending_eff;
    logic [N_IRQ-1:0] cand;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] ack_mask;
    logic [N_IRQ-1:0] eoi_mask;
    logic             cand_valid;
    logic [2:0]       cand_id;
    logic             isr_valid;
    logic [2:0]       isr_id;
    logic             eligible;
    logic             take;

    // Level mode looks straight at the lines; edge mode uses latched edges.
    assign pending_eff = (EDGE != 0) ? pending_q : irq_in;
    assign cand        = pending_eff & enable_q;

    irq_prio_enc #(.N(N_IRQ)) u_cand_enc (
        .req   (cand),
        .valid (cand_valid),
        .id    (cand_id)
    );

    irq_prio_enc #(.N(N_IRQ)) u_isr_enc (
        .req   (isr_q),
        .valid (isr_valid),
        .id    (isr_id)
    );

    // The best candidate is the only one that can be eligible: if it does
    // not outrank the innermost in-service source, nothing lower does either.
    assign eligible = cand_valid && (!isr_valid || (cand_id < isr_id));
    assign take     = (state_q == IRQ_REQ) && ack;

    // A line already high when reset is released must not count as an edge,
    // so detection is suppressed until the copy has sampled the line once.
    assign rise     = irq_in & ~irq_prev_q & {N_IRQ{armed_q}};
    assign ack_mask = take ? (N_IRQ'(1) << irq_id_q) : '0;
    assign eoi_mask = (eoi && isr_valid) ? (N_IRQ'(1) << isr_id) : '0;

    always_comb begin
        enable_d   = en_wr ? en_data : enable_q;
        irq_prev_d = irq_in;
        armed_d    = 1'b1;

        // Ack clears first, so an edge arriving on the same cycle survives.
        if (EDGE != 0) begin
            pending_d = (pending_q & ~ack_mask) | rise;
        end else begin
            pending_d = '0;
        end

        // eoi retires against the pre-ack isr; the freshly acked bit is
        // OR-ed in afterwards and therefore cannot be cleared by that eoi.
        isr_d = (isr_q & ~eoi_mask) | ack_mask;

        state_d   = state_q;
        irq_req_d = irq_req_q;
        irq_id_d  = irq_id_q;

        case (state_q)
            IRQ_IDLE: begin
                if (eligible) begin
                    state_d   = IRQ_REQ;
                    irq_req_d = 1'b1;
                    irq_id_d  = cand_id;
                end
            end
            IRQ_REQ: begin
                if (ack) begin
                    // irq_id stays frozen at the acknowledged source.
                    state_d   = IRQ_HOLD;
                    irq_req_d = 1'b0;
                end else if (eligible) begin
                    // Keep tracking so a higher-priority arrival replaces it.
                    irq_id_d  = cand_id;
                end else begin
                    state_d   = IRQ_IDLE;
                    irq_req_d = 1'b0;
                end
            end
            IRQ_HOLD: begin
                state_d   = IRQ_IDLE;
                irq_req_d = 1'b0;
            end
            default: begin
                state_d   = IRQ_IDLE;
                irq_req_d = 1'b0;
            end
        endcase

        irq_vec_d = PC_W'(irq_vector(32'(BASE_ADDR), 32'(irq_id_d), 32'(STRIDE)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IRQ_IDLE;
            pending_q  <= '0;
            isr_q      <= '0;
            enable_q   <= '0;
            irq_prev_q <= '0;
            armed_q    <= 1'b0;
            irq_req_q  <= 1'b0;
            irq_id_q   <= '0;
            irq_vec_q  <= BASE_ADDR;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            isr_q      <= isr_d;
            enable_q   <= enable_d;
            irq_prev_q <= irq_prev_d;
            armed_q    <= armed_d;
            irq_req_q  <= irq_req_d;
            irq_id_q   <= irq_id_d;
            irq_vec_q  <= irq_vec_d;
        end
    end

    assign irq_req    = irq_req_q;
    assign irq_id     = irq_id_q;
    assign irq_vec    = irq_vec_q;
    assign in_service = |isr_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl
// Scoreboard bench for irq_ctrl (N_IRQ=4, PC_W=9, BASE=256, STRIDE=4, edge
// mode). The driver applies inputs each cycle, advances a behavioural model
// and queues the expected outputs; a monitor pops and compares them one
// cycle-transaction at a time.
// ---------------------------------------------------------------------------
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] irq_in = '0;
    logic       en_wr = 1'b0;
    logic [3:0] en_data = '0;
    logic       ack = 1'b0;
    logic       eoi = 1'b0;
    logic       irq_req;
    logic [8:0] irq_vec;
    logic [2:0] irq_id;
    logic       in_service;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       req;
        logic [2:0] id;
        logic [8:0] vec;
        logic       insvc;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model state
    bit [3:0] m_pend, m_isr, m_en, m_prev;
    bit       m_armed, m_req, m_hold;
    int       m_id;
    bit [3:0] cur_in, cur_en;

    always #5 clk = ~clk;

    irq_ctrl #(
        .N_IRQ     (4),
        .PC_W      (9),
        .BASE_ADDR (9'd256),
        .STRIDE    (4),
        .EDGE      (1)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .en_wr      (en_wr),
        .en_data    (en_data),
        .ack        (ack),
        .eoi        (eoi),
        .irq_req    (irq_req),
        .irq_vec    (irq_vec),
        .irq_id     (irq_id),
        .in_service (in_service)
    );

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Lowest set index, or 8 when the mask is empty (8 outranks nothing).
    function automatic int first_set(input bit [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 8;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_isr = '0; m_en = '0; m_prev = '0;
        m_armed = 0; m_req = 0; m_hold = 0; m_id = 0;
    endtask

    task automatic model_step(input bit [3:0] in_v, input bit enw, input bit [3:0] en_v,
                              input bit ack_v, input bit eoi_v);
        int  best, inner;
        bit  taken;
        exp_t e;
        best  = first_set(m_pend & m_en);
        inner = first_set(m_isr);
        taken = m_req && ack_v;
        // in-service stack: retire innermost, then push the accepted source
        if (eoi_v && inner < 8) m_isr[inner] = 0;
        if (taken) begin
            m_isr[m_id]  = 1;
            m_pend[m_id] = 0;
        end
        if (m_armed) m_pend = m_pend | (in_v & ~m_prev);
        if (m_req) begin
            if (taken) begin m_req = 0; m_hold = 1; end
            else if (best < inner) m_id = best;
            else m_req = 0;
        end else if (m_hold) begin
            m_hold = 0;
        end else if (best < inner) begin
            m_req = 1; m_id = best;
        end
        if (enw) m_en = en_v;
        m_prev  = in_v;
        m_armed = 1;
        e.req   = m_req;
        e.id    = 3'(m_id);
        e.vec   = 9'((256 + m_id * 4) % 512);
        e.insvc = (m_isr != 0);
        exp_q.push_back(e);
    endtask

    task automatic step(input bit [3:0] in_v, input bit enw, input bit [3:0] en_v,
                        input bit ack_v, input bit eoi_v);
        @(negedge clk);
        irq_in = in_v; en_wr = enw; en_data = en_v; ack = ack_v; eoi = eoi_v;
        cur_in = in_v;
        if (enw) cur_en = en_v;
        model_step(in_v, enw, en_v, ack_v, eoi_v);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input bit [3:0] in_v, input int n);
        for (int i = 0; i < n; i++) step(in_v, 0, 4'd0, 0, 0);
    endtask

    // Monitor: one line per cycle transaction.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("irq_req", int'(irq_req), int'(e.req));
            check("irq_id", int'(irq_id), int'(e.id));
            check("irq_vec", int'(irq_vec), int'(e.vec));
            check("in_service", int'(in_service), int'(e.insvc));
            $display("txn t=%0t req=%0b id=%0d vec=%0d insvc=%0b", $time,
                     irq_req, irq_id, irq_vec, in_service);
        end
    end

    initial begin
        bit [3:0] rin;
        bit       a, eo, w;
        model_reset();
        cur_in = '0; cur_en = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", int'(irq_req), 0);
        check("rst_id", int'(irq_id), 0);
        check("rst_vec", int'(irq_vec), 256);
        check("rst_insvc", int'(in_service), 0);
        @(negedge clk);
        reset = 1'b0;

        // Single source 2
        step(4'b0000, 1, 4'b0100, 0, 0);
        step(4'b0100, 0, 0, 0, 0);
        step(4'b0100, 0, 0, 0, 0);
        check("s2_req", int'(irq_req), 1);
        check("s2_id", int'(irq_id), 2);
        check("s2_vec", int'(irq_vec), 264);
        step(4'b0100, 0, 0, 1, 0);
        check("s2_ack_req", int'(irq_req), 0);
        check("s2_ack_insvc", int'(in_service), 1);

        // Nesting: source 0 preempts, source 3 must wait
        step(4'b0100, 1, 4'b1111, 0, 0);
        step(4'b0101, 0, 0, 0, 0);
        step(4'b0101, 0, 0, 0, 0);
        check("nest_id", int'(irq_id), 0);
        check("nest_vec", int'(irq_vec), 256);
        step(4'b0101, 0, 0, 1, 0);
        step(4'b0101, 0, 0, 0, 1);
        step(4'b1101, 0, 0, 0, 0);
        idle(4'b1101, 3);
        check("blocked_req", int'(irq_req), 0);
        step(4'b1101, 0, 0, 0, 1);
        step(4'b1101, 0, 0, 0, 0);
        check("after_eoi_id", int'(irq_id), 3);
        step(4'b1101, 0, 0, 1, 0);
        step(4'b0000, 0, 0, 0, 1);
        idle(4'b0000, 2);

        // Simultaneous 3 and 1
        step(4'b1010, 0, 0, 0, 0);
        step(4'b1010, 0, 0, 0, 0);
        check("pair_first", int'(irq_id), 1);
        step(4'b1010, 0, 0, 1, 0);
        step(4'b1010, 0, 0, 0, 1);
        step(4'b1010, 0, 0, 0, 0);
        check("pair_second", int'(irq_id), 3);
        step(4'b0000, 0, 0, 1, 0);
        step(4'b0000, 0, 0, 0, 1);
        idle(4'b0000, 2);

        // ack and eoi together: isr 0100 plus ack of 0 gives 0001
        step(4'b0100, 0, 0, 0, 0);
        step(4'b0100, 0, 0, 0, 0);
        step(4'b0100, 0, 0, 1, 0);
        step(4'b0101, 0, 0, 0, 0);
        step(4'b0101, 0, 0, 0, 0);
        check("ae_id", int'(irq_id), 0);
        step(4'b0000, 0, 0, 1, 1);
        check("ae_insvc", int'(in_service), 1);
        step(4'b0000, 0, 0, 0, 1);
        check("ae_cleared", int'(in_service), 0);
        idle(4'b0000, 2);

        // Withdrawal by disabling, then re-enable
        step(4'b0010, 0, 0, 0, 0);
        step(4'b0010, 0, 0, 0, 0);
        step(4'b0010, 1, 4'b1101, 0, 0);
        step(4'b0010, 0, 0, 0, 0);
        check("withdraw_req", int'(irq_req), 0);
        step(4'b0010, 1, 4'b1111, 0, 0);
        step(4'b0010, 0, 0, 0, 0);
        check("reenable_req", int'(irq_req), 1);
        check("reenable_id", int'(irq_id), 1);

        // Asynchronous reset during REQ with the line held high
        step(4'b0011, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rst_req", int'(irq_req), 0);
        check("async_rst_insvc", int'(in_service), 0);
        model_reset();
        cur_en = '0;
        @(negedge clk);
        reset = 1'b0;
        step(4'b0011, 1, 4'b1111, 0, 0);
        idle(4'b0011, 3);
        check("post_rst_req", int'(irq_req), 0);
        step(4'b0000, 0, 0, 0, 0);
        step(4'b0001, 0, 0, 0, 0);
        step(4'b0001, 0, 0, 0, 0);
        check("retoggle_req", int'(irq_req), 1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rin = cur_in ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            a   = m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            eo  = ($urandom_range(0, 5) == 0);
            w   = ($urandom_range(0, 9) == 0);
            step(rin, w, 4'($urandom_range(0, 15)), a, eo);
        end

        idle(cur_in, 2);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
